// File: rtl/regincr_out_queue_if.sv
// rtl/regincr_out_queue_if.sv - enqueue/dequeue handshake bundle for regincr_out_queue
//
// Purpose: groups the valid/ready enqueue side, the valid/ready dequeue side
// and the free-entry count of the incrementer output queue.
// Ports (signals):
//   enq_val  producer -> queue   upstream presents valid data
//   enq_rdy  queue -> producer   queue can accept data this cycle
//   enq_msg  producer -> queue   data to enqueue (p_nbits)
//   deq_val  queue -> consumer   queue presents valid data
//   deq_rdy  consumer -> queue   downstream accepts data this cycle
//   deq_msg  queue -> consumer   head-of-queue data (p_nbits)
//   num_free queue -> consumer   number of empty entries
// Modports: master = producer/consumer side, slave = queue side.
interface regincr_out_queue_if #(
  parameter int p_nbits       = 8,
  parameter int p_num_entries = 4
);
  logic                               enq_val;
  logic                               enq_rdy;
  logic [p_nbits-1:0]                 enq_msg;
  logic                               deq_val;
  logic                               deq_rdy;
  logic [p_nbits-1:0]                 deq_msg;
  logic [$clog2(p_num_entries):0]     num_free;

  modport master (
    output enq_val,
    output enq_msg,
    output deq_rdy,
    input  enq_rdy,
    input  deq_val,
    input  deq_msg,
    input  num_free
  );

  modport slave (
    input  enq_val,
    input  enq_msg,
    input  deq_rdy,
    output enq_rdy,
    output deq_val,
    output deq_msg,
    output num_free
  );
endinterface

// File: rtl/regincr_out_queue.sv
// rtl/regincr_out_queue.sv - valid/ready circular-buffer FIFO behind the registered incrementer
//
// Purpose: holds incrementer results until the consumer accepts them.
// Circular buffer with independent enqueue/dequeue pointers and an occupancy
// counter. Optional macro REGINCR_OUT_QUEUE_BYPASS_EN adds an empty-queue
// bypass giving 0-cycle latency when the consumer is ready.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   q      regincr_out_queue_if.slave  enqueue/dequeue handshakes, num_free
// Parameters: p_nbits (data width), p_num_entries (power of two, >= 2).
module regincr_out_queue #(
  parameter int p_nbits       = 8,
  parameter int p_num_entries = 4
) (
  input  logic                clk,
  input  logic                reset,
  regincr_out_queue_if.slave  q
);

  localparam int lp_pw = $clog2(p_num_entries);
  localparam int lp_cw = lp_pw + 1;
  localparam logic [lp_cw-1:0] lp_full = lp_cw'(p_num_entries);

  logic [lp_cw-1:0]   r_count;
  logic [lp_pw-1:0]   r_enq_ptr;
  logic [lp_pw-1:0]   r_deq_ptr;
  logic [p_nbits-1:0] r_entry [p_num_entries];

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_enq_fire;
  logic w_deq_fire;
  logic w_store_enq;
  logic w_store_deq;

  assign w_full  = (r_count == lp_full);
  assign w_empty = (r_count == '0);

`ifdef REGINCR_OUT_QUEUE_BYPASS_EN
  // Empty queue with both sides ready: hand the word straight through.
  assign w_bypass = w_empty & q.enq_val & q.deq_rdy;
`else
  assign w_bypass = 1'b0;
`endif

  // enq_rdy comes from registered state only: no full pass-through.
  assign q.enq_rdy  = ~w_full;
  assign q.deq_val  = ~w_empty | w_bypass;
  assign q.num_free = lp_full - r_count;

  always_comb begin
    q.deq_msg = '0;
    if (w_bypass) begin
      q.deq_msg = q.enq_msg;
    end else if (!w_empty) begin
      q.deq_msg = r_entry[r_deq_ptr];
    end
  end

  assign w_enq_fire = q.enq_val & q.enq_rdy;
  assign w_deq_fire = q.deq_val & q.deq_rdy;

  // A bypassed transfer fires both handshakes but leaves storage untouched.
  assign w_store_enq = w_enq_fire & ~w_bypass;
  assign w_store_deq = w_deq_fire & ~w_bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
    end else begin
      // Pointers wrap by natural overflow since depth is a power of two.
      if (w_store_enq) begin
        r_enq_ptr <= r_enq_ptr + 1'b1;
      end
      if (w_store_deq) begin
        r_deq_ptr <= r_deq_ptr + 1'b1;
      end
      case ({w_store_enq, w_store_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_store_enq) begin
      r_entry[r_enq_ptr] <= q.enq_msg;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_store_enq && !w_store_deq && w_full));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_store_deq && !w_store_enq && w_empty));

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    r_count <= lp_full);

endmodule

// File: tb/tb_regincr_out_queue.sv
// tb/tb_regincr_out_queue.sv - scoreboard bench for regincr_out_queue
module tb_regincr_out_queue;

  logic clk;
  logic reset;

  regincr_out_queue_if #(.p_nbits(8), .p_num_entries(4)) bus ();

  regincr_out_queue #(.p_nbits(8), .p_num_entries(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int n_pop;
  logic [7:0] sb [$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a dequeue fires outside reset.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.deq_val && bus.deq_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_deq", 1, 0);
        end else begin
          check("deq_msg", int'(bus.deq_msg), int'(sb.pop_front()));
        end
        n_pop++;
      end
    end
  end

  // One cycle: drive inputs, check current-state outputs against hand values,
  // record an accepted enqueue in the scoreboard.
  task automatic cyc(input logic ev, input logic [7:0] msg, input logic dr,
                     input logic exp_rdy, input int exp_free, input logic exp_dval);
    bus.enq_val = ev;
    bus.enq_msg = msg;
    bus.deq_rdy = dr;
    @(negedge clk);
    check("enq_rdy",  int'(bus.enq_rdy),  int'(exp_rdy));
    check("num_free", int'(bus.num_free), exp_free);
    check("deq_val",  int'(bus.deq_val),  int'(exp_dval));
    if (!exp_dval) check("deq_msg_empty", int'(bus.deq_msg), 0);
    if (ev && exp_rdy) sb.push_back(msg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_pop   = 0;
    reset = 1'b1;
    bus.enq_val = 1'b0;
    bus.enq_msg = 8'h00;
    bus.deq_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset / idle
    cyc(0, 8'h00, 0, 1, 4, 0);
    // Fill, 5th not accepted
    cyc(1, 8'h01, 0, 1, 4, 0);
    cyc(1, 8'h02, 0, 1, 3, 1);
    cyc(1, 8'h03, 0, 1, 2, 1);
    cyc(1, 8'h04, 0, 1, 1, 1);
    cyc(1, 8'h05, 0, 0, 0, 1);
    // Full plus dequeue: enq_rdy stays 0 this cycle, 1 next
    cyc(1, 8'h05, 1, 0, 0, 1);
    cyc(0, 8'h00, 1, 1, 1, 1);
    // Wrap enqueues
    cyc(1, 8'hFE, 0, 1, 2, 1);
    cyc(1, 8'hFF, 0, 1, 1, 1);
    // Drain two
    cyc(0, 8'h00, 1, 0, 0, 1);
    cyc(0, 8'h00, 1, 1, 1, 1);
    // Simultaneous enq/deq at count 2
    cyc(1, 8'h11, 1, 1, 2, 1);
    cyc(1, 8'h22, 1, 1, 2, 1);
    cyc(0, 8'h00, 0, 1, 2, 1);
    // Drain to empty
    cyc(0, 8'h00, 1, 1, 2, 1);
    cyc(0, 8'h00, 1, 1, 3, 1);
    cyc(0, 8'h00, 1, 1, 4, 0);
    // Mid-operation reset at count 3
    cyc(1, 8'h31, 0, 1, 4, 0);
    cyc(1, 8'h32, 0, 1, 3, 1);
    cyc(1, 8'h33, 0, 1, 2, 1);
    reset = 1'b1;
    bus.enq_val = 1'b1;
    bus.enq_msg = 8'h34;
    bus.deq_rdy = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    cyc(0, 8'h00, 0, 1, 4, 0);
    // Pointers restart at zero after reset
    cyc(1, 8'h44, 0, 1, 4, 0);
    cyc(0, 8'h00, 1, 1, 3, 1);
`ifdef REGINCR_OUT_QUEUE_BYPASS_EN
    cyc(1, 8'h2A, 1, 1, 4, 1);
    cyc(0, 8'h00, 0, 1, 4, 0);
`else
    cyc(1, 8'h2A, 1, 1, 4, 0);
    cyc(0, 8'h00, 1, 1, 3, 1);
`endif
    cyc(0, 8'h00, 0, 1, 4, 0);

    // 01,02,03,04,FE,FF,11,22,44,2A
    check("pop_count", n_pop, 10);
    check("sb_leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
